// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLB maintenance ops (TLBSRCH/TLBRD/TLBWR/TLBFILL/
// INVTLB) onto the TLB array ports, one op in flight, with the result handed
// back over a valid/ready response channel. Also arbitrates the shared
// search-1 port and owns the free-running TLBFILL replacement counter.

package tlb_op_pkg;
  // Per-page translation payload (one half of an even/odd pair).
  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } PhytranItem;
endpackage

module tlb_op_ctrl
  import tlb_op_pkg::*;
#(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high. op_ready is high only in IDLE and does not depend on
  // op_valid. Once rsp_valid rises, every rsp_* output holds still until the
  // edge where rsp_ready is also high.
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_code,
  input  logic [2:0]            op_inv_op,
  input  logic [9:0]            op_asid,
  input  logic [18:0]           op_vppn,
  input  logic [TLBNUMSIZE-1:0] op_index,
  input  logic [5:0]            op_ps,
  input  logic                  op_ne,
  input  logic                  op_g,
  input  PhytranItem            op_pt0,
  input  PhytranItem            op_pt1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [TLBNUMSIZE-1:0] rsp_index,
  output logic [5:0]            rsp_ps,
  output logic [9:0]            rsp_asid,
  output logic [18:0]           rsp_vppn,
  output logic                  rsp_g,
  output PhytranItem            rsp_pt0,
  output PhytranItem            rsp_pt1,
  // MEM-stage translation request, shares the search-1 port
  input  logic [18:0]           mem_vppn,
  input  logic [9:0]            mem_asid,
  input  logic                  mem_odd,
  output logic                  mem_stall,
  // TLB search-1 port
  output logic [18:0]           s1_vppn,
  output logic [9:0]            s1_asid,
  output logic                  s1_odd,
  input  logic                  s1_ne,
  input  logic [TLBNUMSIZE-1:0] s1_index,
  // TLB read port
  output logic [TLBNUMSIZE-1:0] r_index,
  input  logic [5:0]            r_ps,
  input  logic                  r_ne,
  input  logic [9:0]            r_asid,
  input  logic [18:0]           r_vppn,
  input  logic                  r_g,
  input  PhytranItem            r_phytran0,
  input  PhytranItem            r_phytran1,
  // TLB write port
  output logic                  we,
  output logic [TLBNUMSIZE-1:0] w_index,
  output logic [5:0]            w_ps,
  output logic                  w_ne,
  output logic [9:0]            w_asid,
  output logic [18:0]           w_vppn,
  output logic                  w_g,
  output PhytranItem            w_phytran0,
  output PhytranItem            w_phytran1,
  // TLB flush port
  output logic                  fe,
  output logic [9:0]            f_asid,
  output logic [18:0]           f_va,
  output logic [2:0]            f_op,
  // Debug view of the sequencer state
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SRCH  = 3'd1,
    S_RD    = 3'd2,
    S_WRITE = 3'd3,
    S_INV   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t                  r_state;
  logic [2:0]              r_op_code;
  logic [2:0]              r_op_inv_op;
  logic [9:0]              r_op_asid;
  logic [18:0]             r_op_vppn;
  logic [TLBNUMSIZE-1:0]   r_op_index;
  logic [5:0]              r_op_ps;
  logic                    r_op_ne;
  logic                    r_op_g;
  PhytranItem              r_op_pt0;
  PhytranItem              r_op_pt1;
  logic [TLBNUMSIZE-1:0]   r_fill_cnt;

  assign op_ready  = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign r_index   = r_op_index;
  assign dbg_state = r_state;

  // Replacement counter: free-running, never stalls, wraps at TLBNUM-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fill_cnt <= '0;
    end else if (r_fill_cnt == TLBNUMSIZE'(TLBNUM - 1)) begin
      r_fill_cnt <= '0;
    end else begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  // Sequencer: op capture, state transitions and response registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_op_code   <= '0;
      r_op_inv_op <= '0;
      r_op_asid   <= '0;
      r_op_vppn   <= '0;
      r_op_index  <= '0;
      r_op_ps     <= '0;
      r_op_ne     <= 1'b0;
      r_op_g      <= 1'b0;
      r_op_pt0    <= '0;
      r_op_pt1    <= '0;
      rsp_hit     <= 1'b0;
      rsp_index   <= '0;
      rsp_ps      <= '0;
      rsp_asid    <= '0;
      rsp_vppn    <= '0;
      rsp_g       <= 1'b0;
      rsp_pt0     <= '0;
      rsp_pt1     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_op_code   <= op_code;
            r_op_inv_op <= op_inv_op;
            r_op_asid   <= op_asid;
            r_op_vppn   <= op_vppn;
            r_op_index  <= op_index;
            r_op_ps     <= op_ps;
            r_op_ne     <= op_ne;
            r_op_g      <= op_g;
            r_op_pt0    <= op_pt0;
            r_op_pt1    <= op_pt1;
            case (op_code)
              OP_SRCH: r_state <= S_SRCH;
              OP_RD:   r_state <= S_RD;
              OP_WR, OP_FILL: begin
                r_state <= S_WRITE;
                rsp_hit <= 1'b0;
              end
              OP_INV: begin
                r_state <= S_INV;
                rsp_hit <= 1'b0;
              end
              // Illegal codes report a miss without touching the TLB.
              default: begin
                r_state <= S_RESP;
                rsp_hit <= 1'b0;
              end
            endcase
          end
        end
        S_SRCH: begin
          rsp_hit   <= ~s1_ne;
          rsp_index <= s1_ne ? '0 : s1_index;
          r_state   <= S_RESP;
        end
        S_RD: begin
          rsp_hit   <= ~r_ne;
          rsp_ps    <= r_ps;
          rsp_asid  <= r_asid;
          rsp_vppn  <= r_vppn;
          rsp_g     <= r_g;
          rsp_pt0   <= r_phytran0;
          rsp_pt1   <= r_phytran1;
          r_state   <= S_RESP;
        end
        S_WRITE: r_state <= S_RESP;
        S_INV:   r_state <= S_RESP;
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // TLB-facing port drive: search-1 mux, write and flush pulses from state.
  always_comb begin
    s1_vppn    = mem_vppn;
    s1_asid    = mem_asid;
    s1_odd     = mem_odd;
    mem_stall  = 1'b0;
    we         = 1'b0;
    w_index    = '0;
    w_ps       = '0;
    w_ne       = 1'b0;
    w_asid     = '0;
    w_vppn     = '0;
    w_g        = 1'b0;
    w_phytran0 = '0;
    w_phytran1 = '0;
    fe         = 1'b0;
    f_asid     = '0;
    f_va       = '0;
    f_op       = '0;
    case (r_state)
      S_SRCH: begin
        s1_vppn   = r_op_vppn;
        s1_asid   = r_op_asid;
        s1_odd    = 1'b0;
        mem_stall = 1'b1;
      end
      S_WRITE: begin
        we         = 1'b1;
        w_index    = (r_op_code == OP_FILL) ? r_fill_cnt : r_op_index;
        w_ps       = r_op_ps;
        w_ne       = r_op_ne;
        w_asid     = r_op_asid;
        w_vppn     = r_op_vppn;
        w_g        = r_op_g;
        w_phytran0 = r_op_pt0;
        w_phytran1 = r_op_pt1;
      end
      S_INV: begin
        fe     = 1'b1;
        f_op   = r_op_inv_op;
        f_asid = r_op_asid;
        f_va   = r_op_vppn;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: a small behavioural TLB array answers the read and
// search ports, and directed scenario tasks check each op type.
module tb_tlb_op_ctrl;
  import tlb_op_pkg::*;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [2:0]  op_inv_op;
  logic [9:0]  op_asid;
  logic [18:0] op_vppn;
  logic [3:0]  op_index;
  logic [5:0]  op_ps;
  logic        op_ne;
  logic        op_g;
  PhytranItem  op_pt0, op_pt1;
  logic        rsp_valid, rsp_ready, rsp_hit;
  logic [3:0]  rsp_index;
  logic [5:0]  rsp_ps;
  logic [9:0]  rsp_asid;
  logic [18:0] rsp_vppn;
  logic        rsp_g;
  PhytranItem  rsp_pt0, rsp_pt1;
  logic [18:0] mem_vppn;
  logic [9:0]  mem_asid;
  logic        mem_odd, mem_stall;
  logic [18:0] s1_vppn;
  logic [9:0]  s1_asid;
  logic        s1_odd, s1_ne;
  logic [3:0]  s1_index;
  logic [3:0]  r_index;
  logic [5:0]  r_ps;
  logic        r_ne;
  logic [9:0]  r_asid;
  logic [18:0] r_vppn;
  logic        r_g;
  PhytranItem  r_phytran0, r_phytran1;
  logic        we;
  logic [3:0]  w_index;
  logic [5:0]  w_ps;
  logic        w_ne;
  logic [9:0]  w_asid;
  logic [18:0] w_vppn;
  logic        w_g;
  PhytranItem  w_phytran0, w_phytran1;
  logic        fe;
  logic [9:0]  f_asid;
  logic [18:0] f_va;
  logic [2:0]  f_op;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  tlb_op_ctrl #(.TLBNUM(16), .TLBNUMSIZE(4)) dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_inv_op(op_inv_op), .op_asid(op_asid), .op_vppn(op_vppn),
    .op_index(op_index), .op_ps(op_ps), .op_ne(op_ne), .op_g(op_g),
    .op_pt0(op_pt0), .op_pt1(op_pt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_index(rsp_index), .rsp_ps(rsp_ps), .rsp_asid(rsp_asid),
    .rsp_vppn(rsp_vppn), .rsp_g(rsp_g), .rsp_pt0(rsp_pt0), .rsp_pt1(rsp_pt1),
    .mem_vppn(mem_vppn), .mem_asid(mem_asid), .mem_odd(mem_odd),
    .mem_stall(mem_stall),
    .s1_vppn(s1_vppn), .s1_asid(s1_asid), .s1_odd(s1_odd),
    .s1_ne(s1_ne), .s1_index(s1_index),
    .r_index(r_index), .r_ps(r_ps), .r_ne(r_ne), .r_asid(r_asid),
    .r_vppn(r_vppn), .r_g(r_g), .r_phytran0(r_phytran0), .r_phytran1(r_phytran1),
    .we(we), .w_index(w_index), .w_ps(w_ps), .w_ne(w_ne), .w_asid(w_asid),
    .w_vppn(w_vppn), .w_g(w_g), .w_phytran0(w_phytran0), .w_phytran1(w_phytran1),
    .fe(fe), .f_asid(f_asid), .f_va(f_va), .f_op(f_op),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected replacement counter: 0 out of reset, +1 per edge, 4-bit wrap.
  logic [3:0] fill_model;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) fill_model <= 4'd0;
    else         fill_model <= fill_model + 4'd1;
  end

  // ---------------- behavioural TLB array ----------------
  logic        tlb_clr;
  logic        m_ne   [16];
  logic [18:0] m_vppn [16];
  logic [9:0]  m_asid [16];
  logic        m_g    [16];
  logic [5:0]  m_ps   [16];
  PhytranItem  m_pt0  [16];
  PhytranItem  m_pt1  [16];

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (tlb_clr) begin
        m_ne[i] <= 1'b1; m_vppn[i] <= '0; m_asid[i] <= '0; m_g[i] <= 1'b0;
        m_ps[i] <= '0; m_pt0[i] <= '0; m_pt1[i] <= '0;
      end else begin
        if (we && (w_index == 4'(i))) begin
          m_ne[i] <= w_ne; m_vppn[i] <= w_vppn; m_asid[i] <= w_asid;
          m_g[i] <= w_g; m_ps[i] <= w_ps; m_pt0[i] <= w_phytran0;
          m_pt1[i] <= w_phytran1;
        end
        if (fe) begin
          if (f_op == 3'd0 || f_op == 3'd1) m_ne[i] <= 1'b1;
          if (f_op == 3'd5 && !m_g[i] && m_asid[i] == f_asid && m_vppn[i] == f_va)
            m_ne[i] <= 1'b1;
        end
      end
    end
  end

  assign r_ne       = m_ne[r_index];
  assign r_vppn     = m_vppn[r_index];
  assign r_asid     = m_asid[r_index];
  assign r_g        = m_g[r_index];
  assign r_ps       = m_ps[r_index];
  assign r_phytran0 = m_pt0[r_index];
  assign r_phytran1 = m_pt1[r_index];

  // Search: a miss reports a junk index so the zeroing on miss is visible.
  always_comb begin
    s1_ne    = 1'b1;
    s1_index = 4'hf;
    for (int i = 0; i < 16; i++) begin
      if (!m_ne[i] && m_vppn[i] == s1_vppn && (m_g[i] || m_asid[i] == s1_asid)) begin
        s1_ne    = 1'b0;
        s1_index = 4'(i);
      end
    end
  end

  // ---------------- driver ----------------
  int          c_lat, c_we_n, c_fe_n, c_both_n, c_stall_n;
  logic [3:0]  c_w_index, c_fill_exp, c_index;
  logic [18:0] c_w_vppn, c_f_va, c_s1_vppn, c_vppn;
  logic [9:0]  c_w_asid, c_f_asid, c_s1_asid, c_asid;
  logic        c_w_ne, c_w_g, c_s1_odd, c_hit, c_g;
  logic [2:0]  c_f_op;
  logic [5:0]  c_ps;
  PhytranItem  c_w_pt0, c_pt0, c_pt1;

  // Caller is at a negedge with the DUT idle. Drives one op, records TLB
  // port activity per cycle, stops at the negedge where rsp_valid shows.
  // With rel=1 the response is taken and the task returns at the next
  // negedge (DUT idle again); with rel=0 it returns with the response held.
  task automatic do_op(input logic [2:0] code, input bit rel);
    bit got = 0;
    c_lat = 0; c_we_n = 0; c_fe_n = 0; c_both_n = 0; c_stall_n = 0;
    op_code  = code;
    op_valid = 1'b1;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
      if (we) begin
        c_we_n++; c_w_index = w_index; c_w_vppn = w_vppn; c_w_asid = w_asid;
        c_w_ne = w_ne; c_w_g = w_g; c_w_pt0 = w_phytran0; c_fill_exp = fill_model;
      end
      if (fe) begin
        c_fe_n++; c_f_op = f_op; c_f_asid = f_asid; c_f_va = f_va;
      end
      if (we && fe) c_both_n++;
      if (mem_stall) begin
        c_stall_n++; c_s1_vppn = s1_vppn; c_s1_asid = s1_asid; c_s1_odd = s1_odd;
      end
      if (rsp_valid) begin
        got = 1; c_lat = i;
        c_hit = rsp_hit; c_index = rsp_index; c_vppn = rsp_vppn; c_asid = rsp_asid;
        c_ps = rsp_ps; c_g = rsp_g; c_pt0 = rsp_pt0; c_pt1 = rsp_pt1;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rsp_timeout op=%0d got=no_rsp_valid exp=rsp_valid_within_12", code);
    end else if (rel) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_op_ready got=%0b exp=1", op_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if ({we, fe, mem_stall} !== 3'b000) begin failures++; $display("FAIL reset_we_fe_stall got=%b exp=000", {we, fe, mem_stall}); end
    checks++; if ({rsp_hit, rsp_index} !== 5'd0) begin failures++; $display("FAIL reset_rsp got=%0h exp=0", {rsp_hit, rsp_index}); end
    checks++; if ({w_index, w_vppn, f_va} !== 42'd0) begin failures++; $display("FAIL reset_w_f_zero got=%0h exp=0", {w_index, w_vppn, f_va}); end
    // Idle: search-1 port follows the MEM request.
    checks++;
    if ({s1_vppn, s1_asid, s1_odd} !== {19'h07777, 10'h155, 1'b1}) begin
      failures++; $display("FAIL idle_s1_passthru got=%0h exp=%0h", {s1_vppn, s1_asid, s1_odd}, {19'h07777, 10'h155, 1'b1});
    end
  endtask

  task automatic test_write();
    op_index = 4'd5; op_vppn = 19'h12345; op_asid = 10'd3; op_ne = 1'b0; op_g = 1'b0;
    op_ps = 6'd12; op_pt0 = '{20'h00aa5, 2'd3, 2'd1, 1'b1, 1'b1};
    op_pt1 = '{20'h00aa6, 2'd3, 2'd1, 1'b0, 1'b1};
    do_op(3'd2, 1'b1);
    checks++; if (c_we_n !== 1) begin failures++; $display("FAIL wr_we_pulses got=%0d exp=1", c_we_n); end
    checks++; if (c_w_index !== 4'd5) begin failures++; $display("FAIL wr_w_index got=%0d exp=5", c_w_index); end
    checks++;
    if ({c_w_vppn, c_w_asid, c_w_ne, c_w_g} !== {19'h12345, 10'd3, 1'b0, 1'b0}) begin
      failures++; $display("FAIL wr_w_fields got=%0h exp=%0h", {c_w_vppn, c_w_asid, c_w_ne, c_w_g}, {19'h12345, 10'd3, 1'b0, 1'b0});
    end
    checks++; if (c_fe_n !== 0) begin failures++; $display("FAIL wr_no_fe got=%0d exp=0", c_fe_n); end
    checks++; if (c_hit !== 1'b0) begin failures++; $display("FAIL wr_rsp_hit got=%0b exp=0", c_hit); end
  endtask

  task automatic test_read();
    op_index = 4'd5;
    do_op(3'd1, 1'b1);
    checks++; if (c_hit !== 1'b1) begin failures++; $display("FAIL rd_hit got=%0b exp=1", c_hit); end
    checks++;
    if ({c_vppn, c_asid, c_ps, c_g} !== {19'h12345, 10'd3, 6'd12, 1'b0}) begin
      failures++; $display("FAIL rd_fields got=%0h exp=%0h", {c_vppn, c_asid, c_ps, c_g}, {19'h12345, 10'd3, 6'd12, 1'b0});
    end
    checks++; if (c_pt0 !== PhytranItem'({20'h00aa5, 2'd3, 2'd1, 1'b1, 1'b1})) begin failures++; $display("FAIL rd_pt0 got=%0h exp=%0h", c_pt0, {20'h00aa5, 2'd3, 2'd1, 1'b1, 1'b1}); end
    checks++; if (c_pt1 !== PhytranItem'({20'h00aa6, 2'd3, 2'd1, 1'b0, 1'b1})) begin failures++; $display("FAIL rd_pt1 got=%0h exp=%0h", c_pt1, {20'h00aa6, 2'd3, 2'd1, 1'b0, 1'b1}); end
    checks++; if (c_we_n + c_fe_n + c_stall_n !== 0) begin failures++; $display("FAIL rd_side_effect got=%0d exp=0", c_we_n + c_fe_n + c_stall_n); end
    op_index = 4'd6;
    do_op(3'd1, 1'b1);
    checks++; if (c_hit !== 1'b0) begin failures++; $display("FAIL rd_empty_hit got=%0b exp=0", c_hit); end
  endtask

  task automatic test_search_hit();
    op_vppn = 19'h12345; op_asid = 10'd3;
    do_op(3'd0, 1'b1);
    checks++; if (c_stall_n !== 1) begin failures++; $display("FAIL srch_stall_cycles got=%0d exp=1", c_stall_n); end
    checks++;
    if ({c_s1_vppn, c_s1_asid, c_s1_odd} !== {19'h12345, 10'd3, 1'b0}) begin
      failures++; $display("FAIL srch_s1_drive got=%0h exp=%0h", {c_s1_vppn, c_s1_asid, c_s1_odd}, {19'h12345, 10'd3, 1'b0});
    end
    checks++; if ({c_hit, c_index} !== {1'b1, 4'd5}) begin failures++; $display("FAIL srch_hit got=%0h exp=15", {c_hit, c_index}); end
  endtask

  task automatic test_illegal();
    do_op(3'd6, 1'b1);
    checks++; if (c_lat !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", c_lat); end
    checks++; if (c_hit !== 1'b0) begin failures++; $display("FAIL illegal_hit got=%0b exp=0", c_hit); end
    checks++; if (c_we_n + c_fe_n + c_stall_n !== 0) begin failures++; $display("FAIL illegal_side_effect got=%0d exp=0", c_we_n + c_fe_n + c_stall_n); end
  endtask

  task automatic test_search_miss();
    op_vppn = 19'h12345; op_asid = 10'd4;
    do_op(3'd0, 1'b1);
    checks++; if ({c_hit, c_index} !== 5'd0) begin failures++; $display("FAIL srch_miss got=%0h exp=0", {c_hit, c_index}); end
  endtask

  task automatic test_inv();
    op_inv_op = 3'd5; op_asid = 10'd3; op_vppn = 19'h12345;
    do_op(3'd4, 1'b1);
    checks++; if (c_fe_n !== 1) begin failures++; $display("FAIL inv_fe_pulses got=%0d exp=1", c_fe_n); end
    checks++;
    if ({c_f_op, c_f_asid, c_f_va} !== {3'd5, 10'd3, 19'h12345}) begin
      failures++; $display("FAIL inv_f_fields got=%0h exp=%0h", {c_f_op, c_f_asid, c_f_va}, {3'd5, 10'd3, 19'h12345});
    end
    checks++; if (c_we_n !== 0) begin failures++; $display("FAIL inv_no_we got=%0d exp=0", c_we_n); end
    do_op(3'd0, 1'b1);
    checks++; if (c_hit !== 1'b0) begin failures++; $display("FAIL inv_then_srch got=%0b exp=0", c_hit); end
  endtask

  task automatic test_fill();
    op_index = 4'd2; op_vppn = 19'h0abcd; op_asid = 10'd7; op_g = 1'b1; op_ne = 1'b0;
    // Counter reads 14 here, so it is 15 in the write cycle.
    for (int i = 0; i < 32 && fill_model != 4'd14; i++) @(negedge clk);
    do_op(3'd3, 1'b1);
    checks++; if (c_we_n !== 1) begin failures++; $display("FAIL fill_we_pulses got=%0d exp=1", c_we_n); end
    checks++; if (c_w_index !== 4'd15) begin failures++; $display("FAIL fill_index_15 got=%0d exp=15", c_w_index); end
    checks++; if (c_w_vppn !== 19'h0abcd) begin failures++; $display("FAIL fill_vppn got=%0h exp=abcd", c_w_vppn); end
    // Counter reads 15 here, so it has wrapped to 0 in the write cycle.
    op_vppn = 19'h0bcde;
    for (int i = 0; i < 32 && fill_model != 4'd15; i++) @(negedge clk);
    do_op(3'd3, 1'b1);
    checks++; if (c_w_index !== 4'd0) begin failures++; $display("FAIL fill_wrap_0 got=%0d exp=0", c_w_index); end
    op_g = 1'b0;
  endtask

  task automatic test_back_to_back();
    op_index = 4'd9; op_vppn = 19'h00321; op_asid = 10'd9; op_ne = 1'b0; op_ps = 6'd21;
    do_op(3'd2, 1'b1);
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", op_ready); end
    do_op(3'd1, 1'b1);
    checks++; if (c_lat !== 2) begin failures++; $display("FAIL b2b_rd_latency got=%0d exp=2", c_lat); end
    checks++;
    if ({c_hit, c_vppn, c_asid, c_ps} !== {1'b1, 19'h00321, 10'd9, 6'd21}) begin
      failures++; $display("FAIL b2b_rd_data got=%0h exp=%0h", {c_hit, c_vppn, c_asid, c_ps}, {1'b1, 19'h00321, 10'd9, 6'd21});
    end
    checks++; if (c_both_n !== 0) begin failures++; $display("FAIL b2b_we_fe_overlap got=%0d exp=0", c_both_n); end
  endtask

  task automatic test_resp_hold();
    op_vppn = 19'h00321; op_asid = 10'd9;
    do_op(3'd0, 1'b0);
    // A competing WR request must neither be accepted nor write while held.
    op_code = 3'd2; op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, op_ready, we, rsp_hit, rsp_index} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd9}) begin
        failures++; $display("FAIL hold_cycle%0d got=%b exp=%b", i, {rsp_valid, op_ready, we, rsp_hit, rsp_index}, {1'b1, 1'b0, 1'b0, 1'b1, 4'd9});
      end
    end
    op_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, op_ready} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b exp=01", {rsp_valid, op_ready}); end
  endtask

  task automatic test_reset_in_resp();
    op_index = 4'd9;
    do_op(3'd1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, op_ready, rsp_hit} !== 3'b010) begin
      failures++; $display("FAIL async_reset_resp got=%b exp=010", {rsp_valid, op_ready, rsp_hit});
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, op_ready} !== 2'b01) begin failures++; $display("FAIL after_reset_idle got=%b exp=01", {rsp_valid, op_ready}); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    resetn = 1'b0; tlb_clr = 1'b1;
    op_valid = 1'b0; op_code = '0; op_inv_op = '0; op_asid = '0; op_vppn = '0;
    op_index = '0; op_ps = '0; op_ne = 1'b0; op_g = 1'b0; op_pt0 = '0; op_pt1 = '0;
    rsp_ready = 1'b0;
    mem_vppn = 19'h07777; mem_asid = 10'h155; mem_odd = 1'b1;
    repeat (3) @(negedge clk);
    tlb_clr = 1'b0;
    resetn  = 1'b1;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_search_hit();
    test_illegal();
    test_search_miss();
    test_inv();
    test_fill();
    test_back_to_back();
    test_resp_hold();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
